// File: rtl/parking_lane_arbiter.sv
// Single-lane gate arbiter between the entry and exit queues of the parking lot.
// Round-robin on contention, blocks entry when full and exit when empty, and owns the occupancy count.
module parking_lane_arbiter #(
    parameter int CAPACITY = 25,
    parameter int CNT_W    = 5,
    parameter int TIMEOUT  = 1000,
    parameter int GUARD    = 4,
    parameter int TMR_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             enter_done,
    input  logic             exit_done,
    output logic             entry_open,
    output logic             exit_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             timeout,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT_IN,
        S_GRANT_OUT,
        S_GUARD
    } state_t;

    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_t;

    state_t            state, state_next;
    dir_t              last_dir, last_dir_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic [CNT_W-1:0]  count_next;
    logic              timeout_next;
    logic              seq_err_next;
    logic              in_ok;
    logic              out_ok;

    assign full   = (count == CNT_W'(CAPACITY));
    assign empty  = (count == '0);
    assign in_ok  = entry_req & ~full;
    assign out_ok = exit_req & ~empty;

    // NOTE: every output of this block is given a default before the case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_next    = state;
        last_dir_next = last_dir;
        timer_next    = timer + TMR_W'(1);
        count_next    = count;
        timeout_next  = 1'b0;
        seq_err_next  = 1'b0;

        case (state)
            S_IDLE: begin
                timer_next   = '0;
                seq_err_next = enter_done | exit_done;
                // On a tie the direction not served last wins.
                if (in_ok && (!out_ok || last_dir == DIR_OUT)) begin
                    state_next = S_GRANT_IN;
                end else if (out_ok) begin
                    state_next = S_GRANT_OUT;
                end
            end

            S_GRANT_IN: begin
                seq_err_next = exit_done;
                if (enter_done) begin
                    count_next    = count + CNT_W'(1);
                    last_dir_next = DIR_IN;
                    state_next    = S_GUARD;
                    timer_next    = '0;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    timeout_next  = 1'b1;
                    last_dir_next = DIR_IN;
                    state_next    = S_GUARD;
                    timer_next    = '0;
                end
            end

            S_GRANT_OUT: begin
                seq_err_next = enter_done;
                if (exit_done) begin
                    count_next    = count - CNT_W'(1);
                    last_dir_next = DIR_OUT;
                    state_next    = S_GUARD;
                    timer_next    = '0;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    timeout_next  = 1'b1;
                    last_dir_next = DIR_OUT;
                    state_next    = S_GUARD;
                    timer_next    = '0;
                end
            end

            S_GUARD: begin
                seq_err_next = enter_done | exit_done;
                if (timer == TMR_W'(GUARD - 1)) begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end
            end

            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_dir   <= DIR_OUT;
            timer      <= '0;
            count      <= '0;
            timeout    <= 1'b0;
            seq_err    <= 1'b0;
            entry_open <= 1'b0;
            exit_open  <= 1'b0;
        end else begin
            state      <= state_next;
            last_dir   <= last_dir_next;
            timer      <= timer_next;
            count      <= count_next;
            timeout    <= timeout_next;
            seq_err    <= seq_err_next;
            // Gates follow the next state so they open one edge after the request and close on the done edge.
            entry_open <= (state_next == S_GRANT_IN);
            exit_open  <= (state_next == S_GRANT_OUT);
        end
    end

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Bench for parking_lane_arbiter: directed stimulus plus a grant scoreboard checked whenever a gate closes.
module tb_parking_lane_arbiter;

    localparam int CAPACITY = 6;
    localparam int CNT_W    = 3;
    localparam int TIMEOUT  = 8;
    localparam int GUARD    = 4;
    localparam int TMR_W    = 4;
    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    logic             clk = 1'b0;
    logic             reset;
    logic             entry_req;
    logic             exit_req;
    logic             enter_done;
    logic             exit_done;
    logic             entry_open;
    logic             exit_open;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             timeout;
    logic             seq_err;

    parking_lane_arbiter #(
        .CAPACITY(CAPACITY),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .GUARD   (GUARD),
        .TMR_W   (TMR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .enter_done(enter_done),
        .exit_done (exit_done),
        .entry_open(entry_open),
        .exit_open (exit_open),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .timeout   (timeout),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             dir;
        logic [CNT_W-1:0] count;
        logic             tmo;
    } grant_rec_t;

    grant_rec_t sb_q[$];
    grant_rec_t rec;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_count = 0;
    int         open_cycles;
    logic       rst_q   = 1'b1;
    logic       prev_in = 1'b0;
    logic       prev_out = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every grant that ends without reset must match the oldest expected record.
    always @(posedge clk) rst_q = reset;

    always @(negedge clk) begin
        check("mutex", {31'd0, entry_open & exit_open}, 32'd0);
        if (!rst_q && ((prev_in && !entry_open) || (prev_out && !exit_open))) begin
            check("sb_pending", sb_q.size(), (sb_q.size() > 0) ? sb_q.size() : 1);
            if (sb_q.size() > 0) begin
                rec = sb_q.pop_front();
                check("sb_dir", {31'd0, prev_out}, {31'd0, rec.dir});
                check("sb_count", {29'd0, count}, {29'd0, rec.count});
                check("sb_timeout", {31'd0, timeout}, {31'd0, rec.tmo});
            end
        end
        prev_in  = entry_open;
        prev_out = exit_open;
    end

    task automatic wait_open(input logic dir);
        int i = 0;
        while (!(entry_open || exit_open) && i < 20) begin
            tick();
            i++;
        end
        check("grant_seen", {31'd0, entry_open | exit_open}, 32'd1);
        check("grant_dir", {31'd0, exit_open}, {31'd0, dir});
    endtask

    task automatic serve(input logic dir, input int hold);
        grant_rec_t r;
        wait_open(dir);
        repeat (hold) tick();
        exp_count = (dir == DIR_IN) ? exp_count + 1 : exp_count - 1;
        r.dir   = dir;
        r.count = CNT_W'(exp_count);
        r.tmo   = 1'b0;
        sb_q.push_back(r);
        if (dir == DIR_IN) enter_done = 1'b1;
        else               exit_done  = 1'b1;
        tick();
        enter_done = 1'b0;
        exit_done  = 1'b0;
        check("count_after_done", {29'd0, count}, exp_count);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        grant_rec_t r;
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; enter_done = 1'b0; exit_done = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_entry_open", {31'd0, entry_open}, 0);
        check("rst_exit_open", {31'd0, exit_open}, 0);
        check("rst_count", {29'd0, count}, 0);
        check("rst_empty", {31'd0, empty}, 1);
        check("rst_full", {31'd0, full}, 0);
        check("rst_timeout", {31'd0, timeout}, 0);
        check("rst_seq_err", {31'd0, seq_err}, 0);

        // Basic grant: one-edge latency, request drop does not revoke, guard keeps gates shut.
        entry_req = 1'b1;
        tick();
        check("t2_open_latency", {31'd0, entry_open}, 1);
        check("t2_exit_closed", {31'd0, exit_open}, 0);
        entry_req = 1'b0;
        repeat (4) tick();
        check("t2_hold", {31'd0, entry_open}, 1);
        exp_count = 1;
        r = '{dir: DIR_IN, count: 3'd1, tmo: 1'b0};
        sb_q.push_back(r);
        enter_done = 1'b1;
        tick();
        enter_done = 1'b0;
        check("t2_close", {31'd0, entry_open}, 0);
        check("t2_count", {29'd0, count}, 1);
        entry_req = 1'b1;
        for (int i = 0; i < GUARD; i++) begin
            check("t2_guard", {31'd0, entry_open}, 0);
            tick();
        end
        check("t2_idle", {31'd0, entry_open}, 0);
        tick();
        check("t2_regrant", {31'd0, entry_open}, 1);
        entry_req = 1'b0;
        serve(DIR_IN, 1);
        repeat (6) tick();

        // Sequence errors: wrong-direction done mid-grant, done in guard, done in idle.
        entry_req = 1'b1;
        wait_open(DIR_IN);
        entry_req = 1'b0;
        exit_done = 1'b1;
        tick();
        exit_done = 1'b0;
        check("t6_wrong_dir_err", {31'd0, seq_err}, 1);
        check("t6_grant_kept", {31'd0, entry_open}, 1);
        check("t6_count_kept", {29'd0, count}, exp_count);
        tick();
        check("t6_err_pulse", {31'd0, seq_err}, 0);
        check("t6_grant_kept2", {31'd0, entry_open}, 1);
        serve(DIR_IN, 0);
        enter_done = 1'b1;
        tick();
        enter_done = 1'b0;
        check("t6_guard_err", {31'd0, seq_err}, 1);
        check("t6_guard_count", {29'd0, count}, exp_count);
        repeat (3) tick();
        enter_done = 1'b1;
        tick();
        enter_done = 1'b0;
        check("t6_idle_err", {31'd0, seq_err}, 1);
        check("t6_idle_count", {29'd0, count}, exp_count);
        check("t6_idle_closed", {31'd0, entry_open}, 0);

        // Reset mid-grant dominates a simultaneous done pulse.
        tick();
        entry_req = 1'b1;
        wait_open(DIR_IN);
        reset = 1'b1;
        enter_done = 1'b1;
        tick();
        reset = 1'b0; enter_done = 1'b0; entry_req = 1'b0;
        exp_count = 0;
        check("t1_entry_open", {31'd0, entry_open}, 0);
        check("t1_exit_open", {31'd0, exit_open}, 0);
        check("t1_count", {29'd0, count}, 0);
        check("t1_seq_err", {31'd0, seq_err}, 0);
        check("t1_timeout", {31'd0, timeout}, 0);

        // Exit is blocked while empty.
        exit_req = 1'b1;
        repeat (5) begin
            tick();
            check("empty_blocks_exit", {31'd0, exit_open}, 0);
        end
        check("empty_flag", {31'd0, empty}, 1);
        exit_req = 1'b0;

        // Fill to capacity, then entry is blocked until an exit frees a slot.
        entry_req = 1'b1;
        for (int i = 0; i < CAPACITY; i++) serve(DIR_IN, 1);
        check("t3_full", {31'd0, full}, 1);
        check("t3_not_empty", {31'd0, empty}, 0);
        repeat (10) begin
            tick();
            check("t3_full_blocks_entry", {31'd0, entry_open}, 0);
        end
        exit_req = 1'b1;
        serve(DIR_OUT, 1);
        check("t3_full_cleared", {31'd0, full}, 0);

        // Both requests held: grants alternate.
        for (int i = 0; i < 2; i++) begin
            serve(DIR_IN, 1);
            serve(DIR_OUT, 1);
        end
        exit_req = 1'b0;

        // Timeout: gate open exactly TIMEOUT cycles, count unchanged, re-grant afterwards.
        r = '{dir: DIR_IN, count: CNT_W'(exp_count), tmo: 1'b1};
        sb_q.push_back(r);
        wait_open(DIR_IN);
        open_cycles = 0;
        while (entry_open && open_cycles < 30) begin
            open_cycles++;
            tick();
        end
        check("t5_open_cycles", open_cycles, TIMEOUT);
        check("t5_timeout_pulse", {31'd0, timeout}, 1);
        check("t5_count_kept", {29'd0, count}, exp_count);
        tick();
        check("t5_timeout_1cyc", {31'd0, timeout}, 0);
        wait_open(DIR_IN);
        entry_req = 1'b0;
        serve(DIR_IN, 1);

        repeat (8) tick();
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
